// File: rtl/ram_arbiter.sv
// Two-master arbiter and sequencer in front of a single-read/single-write
// synchronous RAM. Master 0 is instruction fetch, master 1 is load/store.
// Round-robin between masters, with an optional lock that lets one master
// keep the port for a bounded number of consecutive grants while the other
// master waits. Read data returns one cycle after the grant, qualified by a
// per-master valid strobe.
module ram_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,

    output logic [DW-1:0] rdata,

    output logic          ram_we,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    // Burst counter must be able to hold MAX_BURST itself (it saturates there).
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          last;       // master granted most recently (0/1)
    logic          locked;     // owner asked to keep the port
    logic          owner;      // master holding (or last holding) the lock
    logic [CW-1:0] cnt;        // consecutive grants to the locking owner

    logic          req_owner;
    logic          req_other;
    logic          hold;
    logic          gnt_any;
    logic          gnt_sel;    // 0 = master 0, 1 = master 1
    logic          sel_we;
    logic          sel_lock;

    // Grant decision: a locking owner keeps the port until its burst budget is
    // spent while the other master waits; otherwise plain round-robin.
    always_comb begin
        req_owner = owner ? m1_req : m0_req;
        req_other = owner ? m0_req : m1_req;
        hold      = locked && req_owner && ((cnt < CNT_MAX) || !req_other);
        gnt_any   = 1'b0;
        gnt_sel   = 1'b0;
        if (rst) begin
            gnt_any = 1'b0;
        end else if (hold) begin
            gnt_any = 1'b1;
            gnt_sel = owner;
        end else if (m0_req && m1_req) begin
            gnt_any = 1'b1;
            gnt_sel = ~last;
        end else if (m0_req) begin
            gnt_any = 1'b1;
            gnt_sel = 1'b0;
        end else if (m1_req) begin
            gnt_any = 1'b1;
            gnt_sel = 1'b1;
        end
    end

    assign m0_gnt   = gnt_any && !gnt_sel;
    assign m1_gnt   = gnt_any &&  gnt_sel;
    assign sel_we   = gnt_sel ? m1_we   : m0_we;
    assign sel_lock = gnt_sel ? m1_lock : m0_lock;

    // The granted master drives both RAM ports; gnt_sel is 0 with no grant,
    // so an idle read port simply follows master 0's address.
    assign ram_we     = gnt_any && sel_we;
    assign ram_w_addr = gnt_sel ? m1_addr  : m0_addr;
    assign ram_w_data = gnt_sel ? m1_wdata : m0_wdata;
    assign ram_r_addr = gnt_sel ? m1_addr  : m0_addr;
    assign rdata      = ram_r_data;

    // Arbitration history, lock/burst tracking and read-valid strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            locked    <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (gnt_any) begin
                last   <= gnt_sel;
                locked <= sel_lock;
                owner  <= gnt_sel;
                if ((gnt_sel == owner) && locked) begin
                    cnt <= (cnt < CNT_MAX) ? cnt + CNT_ONE : CNT_MAX;
                end else begin
                    cnt <= CNT_ONE;
                end
            end else begin
                locked <= 1'b0;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural 32x32 RAM sits on the RAM ports, grant
// sequences are checked against hand-derived expectations, and every granted
// read pushes its expected data to a scoreboard popped on rvalid.
module tb_ram_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_w_addr;
    logic [DW-1:0] ram_w_data;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_r_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          master;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] exp_mem [32];

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata),
        .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    // Behavioural RAM: write at the edge, read address registered at the edge.
    logic [DW-1:0] mem [32];
    logic [AW-1:0] raddr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_w_addr] <= ram_w_data;
        raddr_q <= ram_r_addr;
    end
    assign ram_r_data = mem[raddr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid || m1_rvalid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected cyc %0d: rvalid m0=%b m1=%b with nothing outstanding", cyc, m0_rvalid, m1_rvalid);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ((m0_rvalid && m1_rvalid) || (m1_rvalid ? 1 : 0) != e.master
                        || rdata !== e.data || e.due != cyc) begin
                        errors++;
                        $display("FAIL sb_read cyc %0d: got m0v=%b m1v=%b rdata=%h, want master %0d rdata=%h at cyc %0d",
                                 cyc, m0_rvalid, m1_rvalid, rdata, e.master, e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_missing cyc %0d: no rvalid, want master %0d rdata=%h", cyc, sb[0].master, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wd;
    endtask

    task automatic idle_all();
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive0(1, 1, 0, 5'd1, 32'h1111_1111);
        drive1(1, 1, 0, 5'd2, 32'h2222_2222);
        tick();
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got m0=%b m1=%b, want 0 0", m0_gnt, m1_gnt);
        end
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ram_we: got %b, want 0", ram_we);
        end
        checks++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: got m0=%b m1=%b, want 0 0", m0_rvalid, m1_rvalid);
        end
        tick();
        idle_all();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_after_write();
        drive1(1, 1, 0, 5'd3, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || ram_we !== 1'b1
            || ram_w_addr !== 5'd3 || ram_w_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_write: got gnt=%b%b we=%b waddr=%0d wdata=%h, want gnt=10 we=1 waddr=3 wdata=deadbeef",
                     m1_gnt, m0_gnt, ram_we, ram_w_addr, ram_w_data);
        end
        exp_mem[3] = 32'hDEAD_BEEF;
        tick();
        drive1(0, 0, 0, '0, '0);
        drive0(1, 0, 0, 5'd3, '0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_we !== 1'b0 || ram_r_addr !== 5'd3) begin
            errors++;
            $display("FAIL raw_read_gnt: got gnt=%b%b we=%b raddr=%0d, want gnt=01 we=0 raddr=3",
                     m1_gnt, m0_gnt, ram_we, ram_r_addr);
        end
        sb.push_back('{0, 32'hDEAD_BEEF, cyc + 1});
        tick();
        idle_all();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_rvalid: got m0v=%b m1v=%b rdata=%h, want 1 0 deadbeef", m0_rvalid, m1_rvalid, rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL raw_pulse: got m0_rvalid=%b one cycle later, want 0", m0_rvalid);
        end
        tick();
    endtask

    task automatic test_top_addr();
        drive0(1, 1, 0, 5'd0, 32'hA5A5_A5A5);
        @(negedge clk);
        exp_mem[0] = 32'hA5A5_A5A5;
        tick();
        drive0(0, 0, 0, '0, '0);
        drive1(1, 1, 0, 5'd31, 32'h1234_5678);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || ram_we !== 1'b1 || ram_w_addr !== 5'd31 || ram_w_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL top_write: got gnt1=%b we=%b waddr=%0d wdata=%h, want 1 1 31 12345678",
                     m1_gnt, ram_we, ram_w_addr, ram_w_data);
        end
        exp_mem[31] = 32'h1234_5678;
        tick();
        drive1(1, 0, 0, 5'd31, '0);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || ram_r_addr !== 5'd31) begin
            errors++;
            $display("FAIL top_read_gnt: got gnt1=%b raddr=%0d, want 1 31", m1_gnt, ram_r_addr);
        end
        sb.push_back('{1, exp_mem[31], cyc + 1});
        tick();
        drive1(0, 0, 0, '0, '0);
        drive0(1, 0, 0, 5'd0, '0);
        @(negedge clk);
        sb.push_back('{0, exp_mem[0], cyc + 1});
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        drive0(1, 0, 0, 5'd3, '0);
        drive1(1, 0, 0, 5'd31, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_gnt step %0d: got m0=%b m1=%b, want master %0d", i, m0_gnt, m1_gnt, i % 2);
            end
            sb.push_back('{i % 2, (i % 2 == 0) ? exp_mem[3] : exp_mem[31], cyc + 1});
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_burst_lock();
        int exp_g [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        drive0(1, 0, 1, 5'd3, '0);
        drive1(1, 0, 0, 5'd31, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (m0_gnt !== (exp_g[i] == 0) || m1_gnt !== (exp_g[i] == 1)) begin
                errors++;
                $display("FAIL burst_gnt step %0d: got m0=%b m1=%b, want master %0d", i, m0_gnt, m1_gnt, exp_g[i]);
            end
            sb.push_back('{exp_g[i], (exp_g[i] == 0) ? exp_mem[3] : exp_mem[31], cyc + 1});
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_lock_saturate();
        logic [DW-1:0] wd;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wd = $urandom;
            drive0(1, 1, 1, 5'(8 + i), wd);
            @(negedge clk);
            checks++;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_we !== 1'b1
                || ram_w_addr !== 5'(8 + i) || ram_w_data !== wd) begin
                errors++;
                $display("FAIL sat_write step %0d: got gnt=%b%b we=%b waddr=%0d wdata=%h, want gnt=01 we=1 waddr=%0d wdata=%h",
                         i, m1_gnt, m0_gnt, ram_we, ram_w_addr, ram_w_data, 8 + i, wd);
            end
            exp_mem[8 + i] = wd;
            tick();
        end
        drive0(1, 1, 1, 5'd18, 32'hFFFF_0000);
        drive1(1, 0, 0, 5'd9, '0);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || ram_we !== 1'b0 || ram_r_addr !== 5'd9) begin
            errors++;
            $display("FAIL sat_rotate: got gnt=%b%b we=%b raddr=%0d, want gnt=10 we=0 raddr=9",
                     m1_gnt, m0_gnt, ram_we, ram_r_addr);
        end
        sb.push_back('{1, exp_mem[9], cyc + 1});
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_reset_midread();
        do_reset();
        drive0(1, 0, 0, 5'd3, '0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got m0_gnt=%b, want 1", m0_gnt);
        end
        tick();
        rst = 1'b1;
        drive1(1, 1, 0, 5'd5, 32'hBAD0_BAD0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || ram_we !== 1'b0
                || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold step %0d: got rv=%b%b we=%b gnt=%b%b, want all 0",
                         i, m1_rvalid, m0_rvalid, ram_we, m1_gnt, m0_gnt);
            end
            tick();
        end
        rst = 1'b0;
        drive1(1, 0, 0, 5'd31, '0);
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_tie: got m0=%b m1=%b, want m0 granted", m0_gnt, m1_gnt);
        end
        sb.push_back('{0, exp_mem[3], cyc + 1});
        tick();
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_drain();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d reads outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        rst = 1'b1;
        idle_all();
        test_reset();
        test_read_after_write();
        test_top_addr();
        test_round_robin();
        test_burst_lock();
        test_lock_saturate();
        test_reset_midread();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer for the 32x32 single-read/single-write synchronous RAM.
- Multiplexes master requests onto the RAM write port and registered-read-address port, with round-robin fairness and optional bounded burst locking.
- Returns read data one cycle after grant, qualified by a per-master valid strobe.
- Sits between the core's requesters (master 0 = instruction fetch, master 1 = load/store) and the RAM.

Parameters:
AW, 5, address width (RAM depth 2**AW).
DW, 32, data width.
MAX_BURST, 4, maximum consecutive grants held by a locking master while the other master waits (>=1).

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
m0_req  input  1  master 0 access request
m0_we  input  1  master 0 write (1) / read (0)
m0_lock  input  1  master 0 requests to retain ownership next cycle
m0_addr  input  AW  master 0 address
m0_wdata  input  DW  master 0 write data
m0_gnt  output  1  master 0 granted this cycle (combinational)
m0_rvalid  output  1  rdata holds master 0 read result this cycle
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid  same as m0_*, for master 1
rdata  output  DW  shared read data, equal to ram_r_data
ram_we  output  1  RAM write enable
ram_w_addr  output  AW  RAM write address
ram_w_data  output  DW  RAM write data
ram_r_addr  output  AW  RAM read address (RAM registers it on posedge)
ram_r_data  input  DW  RAM read data (valid the cycle after its address is registered)

Behaviour:
- Reset (async, rst=1): last=1, locked=0, owner=0, cnt=0, both rvalid=0; gnt, ram_we forced 0 while rst high. Any in-flight read is dropped (no rvalid after reset).
- Grant, combinational, at most one gnt per cycle:
  - if locked and req[owner] and (cnt<MAX_BURST or !req[other]): grant owner.
  - else if one req only: grant it.
  - else if both req: grant master != last.
  - no req: no gnt.
- Granted master drives RAM:
  - write: ram_we=1, ram_w_addr=addr, ram_w_data=wdata.
  - read: ram_we=0, ram_r_addr=addr.
  - When no grant, ram_we=0; ram_r_addr = master 0 addr (don't care).
- Read latency: read granted in cycle t gives mX_rvalid=1 in cycle t+1, with rdata = mem[addr]. rvalid is a register: 1 cycle pulse per granted read.
- Writes complete at the grant edge. No response strobe.
- Same master write in cycle t then read of same address in t+1 returns the new data.
- Sequential state on posedge when grant to X:
  - last<=X.
  - If X==owner and locked: cnt<=min(cnt+1, MAX_BURST), else cnt<=1.
  - locked<=mX_lock; owner<=X.
- No grant: locked<=0, cnt<=0.
- Lock is released when:
  - the owner is granted with lock=0,
  - the owner drops req, or
  - the other master wins after cnt reaches MAX_BURST (forced rotation).
- Saturation: with cnt==MAX_BURST and other idle, owner keeps being granted; cnt holds at MAX_BURST.
- Masters must hold req/we/addr/wdata stable until gnt. Dropping req before gnt is allowed (request withdrawn, no side effects).

Test Plan:
- Reset then m0 read addr 3 (mem[3]=0xDEADBEEF preloaded via m1 write): m0_gnt same cycle; next cycle m0_rvalid=1, rdata=0xDEADBEEF; m1_rvalid=0.
- Both req continuously, no lock, 6 cycles: grants alternate 0,1,0,1,0,1 (m0 first after reset).
- MAX_BURST=4, both req, m0_lock=1 held: m0 granted 4 consecutive cycles, then m1; m0 regains on next tie.
- m0 lock with m1 idle for 10 cycles: m0 granted every cycle. m1 raises req in cycle 10: granted in cycle 10 (cnt saturated).
- m1 write 0x12345678 @ addr 31, then m1 read addr 31 next cycle: rvalid one cycle later, rdata=0x12345678; no wrap to addr 0.
- Assert rst while a m0 read is granted: no m0_rvalid afterwards, ram_we=0 during reset, first post-reset tie grants m0.
